// File: rtl/fixed_point_pkg.sv
// Shared types and the per-stage shift rule for the fixed-point denormalize pipeline.
package fixed_point_pkg;

  // Widest data path the shift-rule helper supports; instances must keep N <= MaxN.
  localparam int unsigned MaxN = 256;
  localparam logic [MaxN-1:0] One = MaxN'(1);

  typedef struct packed {
    logic guard;
    logic sticky;
  } flags_t;

  // Guard/sticky update for a right shift by m (m >= 1); data is zero-extended to MaxN.
  function automatic flags_t shift_flags(input logic [MaxN-1:0] data,
                                         input logic            guard,
                                         input logic            sticky,
                                         input int unsigned     m);
    logic [MaxN-1:0] guard_bit;
    flags_t          r;
    guard_bit = One << (m - 1);
    r.guard   = |(data & guard_bit);
    r.sticky  = sticky | guard | (|(data & (guard_bit - One)));
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_denormalize_stage.sv
// One log-shifter pipeline stage: conditional right shift by SHIFT with guard/sticky tracking.
module fixed_point_denormalize_stage
  import fixed_point_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned SHIFT   = 1,
  parameter bit          RoundEn = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [N-1:0]         data_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  input  logic [$clog2(N)-1:0] count_i,
  input  logic                 adv_next_i,
  output logic                 adv_o,
  output logic                 valid_o,
  output logic [N-1:0]         data_o,
  output logic                 guard_o,
  output logic                 sticky_o,
  output logic [$clog2(N)-1:0] count_o
);

  localparam int unsigned S   = $clog2(N);
  localparam int unsigned Bit = $clog2(SHIFT);

  typedef struct packed {
    logic [N-1:0] data;
    logic         guard;
    logic         sticky;
    logic [S-1:0] count;
  } payload_t;

  payload_t     stage_q, stage_d;
  logic         valid_q;
  logic [N-1:0] shifted;
  logic [N-1:0] data_d;
  flags_t       flags;

  always_comb begin
    shifted      = data_i;
    flags.guard  = guard_i;
    flags.sticky = sticky_i;
    if (count_i[Bit]) begin
      shifted = data_i >> SHIFT;
      flags   = shift_flags(MaxN'(data_i), guard_i, sticky_i, SHIFT);
    end
  end

  if (RoundEn) begin : g_round
    // Nearest-even; no overflow since any set guard implies a nonzero shift.
    logic round_up;
    assign round_up = flags.guard & (flags.sticky | shifted[0]);
    assign data_d   = shifted + N'(round_up);
  end else begin : g_trunc
    assign data_d = shifted;
  end

  always_comb begin
    stage_d.data   = data_d;
    stage_d.guard  = flags.guard;
    stage_d.sticky = flags.sticky;
    stage_d.count  = count_i;
  end

  assign adv_o = ~valid_q | adv_next_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else if (adv_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        stage_q <= stage_d;
      end
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = stage_q.data;
  assign guard_o  = stage_q.guard;
  assign sticky_o = stage_q.sticky;
  assign count_o  = stage_q.count;

endmodule

// File: rtl/fixed_point_denormalize.sv
// Pipelined right-shift denormalizer with valid/ready on both ends.
// Define FIXED_POINT_DENORMALIZE_ROUND_EN to round the result to nearest-even.
module fixed_point_denormalize
  import fixed_point_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         c,
  output logic                 guard,
  output logic                 sticky
);

  localparam int unsigned S = $clog2(N);

`ifdef FIXED_POINT_DENORMALIZE_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  // Index k is the input of stage k; index S is the output of the last stage.
  logic [S:0]   stg_valid;
  logic [N-1:0] stg_data [S+1];
  logic [S:0]   stg_guard;
  logic [S:0]   stg_sticky;
  logic [S:0]   stg_adv;
  logic [S-1:0] stg_count [S];
  logic [S-1:0] count_last_unused;

  assign stg_valid[0]  = in_valid;
  assign stg_data[0]   = a;
  assign stg_guard[0]  = 1'b0;
  assign stg_sticky[0] = 1'b0;
  assign stg_count[0]  = count;
  assign stg_adv[S]    = out_ready;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [S-1:0] count_out;

    fixed_point_denormalize_stage #(
      .N       (N),
      .SHIFT   (2 ** k),
      .RoundEn (RoundEn && (k == S - 1))
    ) u_stage (
      .clk_i      (clk),
      .rst_i      (rst),
      .valid_i    (stg_valid[k]),
      .data_i     (stg_data[k]),
      .guard_i    (stg_guard[k]),
      .sticky_i   (stg_sticky[k]),
      .count_i    (stg_count[k]),
      .adv_next_i (stg_adv[k+1]),
      .adv_o      (stg_adv[k]),
      .valid_o    (stg_valid[k+1]),
      .data_o     (stg_data[k+1]),
      .guard_o    (stg_guard[k+1]),
      .sticky_o   (stg_sticky[k+1]),
      .count_o    (count_out)
    );

    if (k < S - 1) begin : g_fwd
      assign stg_count[k+1] = count_out;
    end else begin : g_last
      assign count_last_unused = count_out;
    end
  end

  assign in_ready  = stg_adv[0];
  assign out_valid = stg_valid[S];
  assign c         = stg_data[S];
  assign guard     = stg_guard[S];
  assign sticky    = stg_sticky[S];

endmodule

// File: tb/tb_fixed_point_denormalize.sv
// Scoreboard bench for fixed_point_denormalize (N=32), directed vectors plus random bubbles.
module tb_fixed_point_denormalize;

  localparam int unsigned N = 32;
  localparam int unsigned S = 5;

`ifdef FIXED_POINT_DENORMALIZE_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [S-1:0] count = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] c;
  logic         guard;
  logic         sticky;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_out    = 0;
  int base;
  bit done     = 1'b0;

  typedef struct {
    logic [31:0] c;
    logic        g;
    logic        s;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  n;
    logic [31:0] ct;
    logic [31:0] cr;
    logic        g;
    logic        s;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs [14];
  vec_t bp [6];

  fixed_point_denormalize #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .guard     (guard),
    .sticky    (sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual c=%h required no output", c);
      end else begin
        mon_e = sb.pop_front();
        check("result{c,g,s}", 64'({c, guard, sticky}), 64'({mon_e.c, mon_e.g, mon_e.s}));
        if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'(5));
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [4:0] cv, input logic [31:0] ec,
                      input logic eg, input logic es, input bit lat);
    int   t;
    exp_t e;
    in_valid = 1'b1;
    a        = av;
    count    = cv;
    t        = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual in_ready=0 required in_ready=1");
    end else begin
      e.c   = ec;
      e.g   = eg;
      e.s   = es;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    #1 check("drain_pending", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [31:0] av, input logic [4:0] cv,
                       output logic [31:0] ec, output logic eg, output logic es);
    logic [31:0] below;
    below = (32'h1 << cv) >> 1;
    ec    = av >> cv;
    eg    = (cv != 0) && ((av & below) != 0);
    es    = (cv > 1) && ((av & (below - 32'h1)) != 0);
    if (RoundEn) ec = ec + 32'(eg & (es | ec[0]));
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ec;
    logic        eg, es;

    //            a             n   trunc c       round c       g     s
    vecs = '{'{32'h80000000, 5'd31, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
             '{32'hFFFFFFFF, 5'd4,  32'h0FFFFFFF, 32'h10000000, 1'b1, 1'b1},
             '{32'h00000003, 5'd1,  32'h00000001, 32'h00000002, 1'b1, 1'b0},
             '{32'h00000005, 5'd1,  32'h00000002, 32'h00000002, 1'b1, 1'b0},
             '{32'h12345678, 5'd0,  32'h12345678, 32'h12345678, 1'b0, 1'b0},
             '{32'hDEADBEEF, 5'd31, 32'h00000001, 32'h00000002, 1'b1, 1'b1},
             '{32'h00000100, 5'd8,  32'h00000001, 32'h00000001, 1'b0, 1'b0},
             '{32'h00000180, 5'd8,  32'h00000001, 32'h00000002, 1'b1, 1'b0},
             '{32'h00000040, 5'd8,  32'h00000000, 32'h00000000, 1'b0, 1'b1},
             '{32'hF0000000, 5'd16, 32'h0000F000, 32'h0000F000, 1'b0, 1'b0},
             '{32'h0000FFFF, 5'd16, 32'h00000000, 32'h00000001, 1'b1, 1'b1},
             '{32'hAAAAAAAA, 5'd1,  32'h55555555, 32'h55555555, 1'b0, 1'b0},
             '{32'h55555555, 5'd3,  32'h0AAAAAAA, 32'h0AAAAAAB, 1'b1, 1'b1},
             '{32'h00000007, 5'd2,  32'h00000001, 32'h00000002, 1'b1, 1'b1}};
    bp = '{'{32'h000000F0, 5'd0, 32'h000000F0, 32'h000000F0, 1'b0, 1'b0},
           '{32'h000000F0, 5'd1, 32'h00000078, 32'h00000078, 1'b0, 1'b0},
           '{32'h000000F0, 5'd2, 32'h0000003C, 32'h0000003C, 1'b0, 1'b0},
           '{32'h000000F0, 5'd3, 32'h0000001E, 32'h0000001E, 1'b0, 1'b0},
           '{32'h000000F0, 5'd4, 32'h0000000F, 32'h0000000F, 1'b0, 1'b0},
           '{32'h000000F0, 5'd5, 32'h00000007, 32'h00000008, 1'b1, 1'b0}};

    // Reset state, sampled mid-cycle while reset is held.
    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_c_g_s", 64'({c, guard, sticky}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_reset_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].n, RoundEn ? vecs[i].cr : vecs[i].ct, vecs[i].g, vecs[i].s,
           i == 0);
    end
    drain();

    // Backpressure: five fill the pipe, the sixth must wait.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(bp[i].a, bp[i].n, RoundEn ? bp[i].cr : bp[i].ct, bp[i].g, bp[i].s, 1'b0);
    end
    in_valid = 1'b1;
    a        = bp[5].a;
    count    = bp[5].n;
    @(negedge clk);
    check("bp_full_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    base = n_out;
    send(bp[5].a, bp[5].n, RoundEn ? bp[5].cr : bp[5].ct, bp[5].g, bp[5].s, 1'b0);
    repeat (5) @(negedge clk);
    #1 check("bp_back_to_back_outputs", 64'(n_out - base), 64'(6));
    drain();

    // Random bubbles on both sides against the golden model.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] av;
          logic [4:0]  cv;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          av = $urandom;
          if ($urandom_range(0, 3) == 0) av = av >> $urandom_range(0, 31);
          cv = 5'($urandom_range(0, 31));
          model(av, cv, ec, eg, es);
          send(av, cv, ec, eg, es, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with work in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].a, vecs[i].n, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 check("stalled_out_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1 check("async_reset_out_valid", 64'(out_valid), 64'(0));
    check("async_reset_c_g_s", 64'({c, guard, sticky}), 64'(0));
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 check("reset_release_in_ready", 64'(in_ready), 64'(1));
    base = n_out;
    send(32'hFFFFFFFF, 5'd4, RoundEn ? 32'h10000000 : 32'h0FFFFFFF, 1'b1, 1'b1, 1'b1);
    drain();
    repeat (8) @(posedge clk);
    #1 check("post_reset_output_count", 64'(n_out - base), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_point_denormalize.md
Name: fixed_point_denormalize

Overview:
- Inverse of the leading-zero-count/normalize path. Takes a normalized N-bit fixed-point word and a $clog2(N)-bit shift count, which is the same encoding a leading-zero counter produces.
- Right-shifts the word by that count to restore fixed-point alignment, tracking guard and sticky bits.
- Pipelined log-shifter with one stage per count bit and valid/ready handshakes on both ends.
- Used after normalized arithmetic to convert results back to fixed point.

Parameters:
- N, 32, data width in bits; power of two, at least 4.
- S (localparam), $clog2(N), number of pipeline stages and count width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/count valid.
- in_ready  output  1  block can accept a/count this cycle.
- a  input  N  normalized operand.
- count  input  S  right-shift amount, 0..N-1.
- out_valid  output  1  c/guard/sticky valid.
- out_ready  input  1  downstream accepts this cycle.
- c  output  N  shifted (optionally rounded) result.
- guard  output  1  last bit shifted out (bit below result LSB).
- sticky  output  1  OR of all shifted-out bits below guard.

Behaviour:
- Reset (async, immediate): all stage valid bits cleared. out_valid=0, c=0, guard=0, sticky=0. in_ready=1 after reset deasserts. In-flight data is discarded.
- Stage k (k=0..S-1) registers {valid, data[N-1:0], guard, sticky, remaining count bits}. It applies a right shift by 2^k when count bit k is set, otherwise passes through.
- Shift rule for amount m=2^k when count bit k is set:
  - new_data = data >> m, zero fill.
  - new_guard = data[m-1].
  - new_sticky = sticky | guard | (m>1 ? |data[m-2:0] : 0).
- Stage 0 takes inputs with guard=0 and sticky=0.
- Outputs are driven directly from the stage S-1 registers.
- Latency: S cycles from accepted input to out_valid when unstalled (5 for N=32). Throughput is 1 result per cycle.
- Flow control, bubble-collapsing:
  - adv[S-1] = !valid[S-1] | out_ready.
  - adv[k] = !valid[k] | adv[k+1].
  - in_ready = adv[0].
  - Input accepted when in_valid & in_ready.
- A stage holds its contents when adv is low. When adv is high it loads the previous stage (valid=0 if the previous stage is empty or not transferring).
- Simultaneous accept and emit with a full pipeline is allowed: in_ready=1 when out_ready=1.
- Output must hold stable while out_valid & !out_ready.
- count=0: result equals a; guard=0, sticky=0.
- count=N-1: result is a[N-1] in bit 0; all other shifted-out bits go to guard/sticky.
- in_valid is ignored while in_ready=0. Upstream must hold a/count stable until accepted.

Optional Feature:
- Macro: FIXED_POINT_DENORMALIZE_ROUND_EN.
- Defined: round-to-nearest-even is applied in the final stage's register input, with no added latency.
  - Rounded value = shifted data + (guard & (sticky | data[0])).
  - Overflow cannot occur, because guard can only be set when count≥1, which leaves the MSB zero.
  - guard/sticky outputs still report the pre-round bits.
- Not defined: c is the truncated shift result; no incrementer is instantiated.

Decomposition:
- Package fixed_point_pkg holds:
  - a typedef struct for the stage payload (data, guard, sticky, count); N-generic via parameterized width or a per-instance typedef in the module;
  - a function computing the shift rule for a given m, shared by the stage sub-module.
- Sub-module fixed_point_denormalize_stage:
  - parameter N and SHIFT=2^k;
  - one pipeline register plus its shift logic and adv handling;
  - instantiated S times in a generate loop.
- Top level does handshake wiring and, when the macro is defined, rounding.

Test Plan:
- a=0x80000000, count=31, out_ready=1 -> c=0x00000001, guard=0, sticky=0, out_valid exactly 5 cycles after accept.
- a=0xFFFFFFFF, count=4 -> c=0x0FFFFFFF, guard=1, sticky=1. With ROUND_EN, c=0x10000000.
- Round-to-even (ROUND_EN): a=0x3, count=1 -> c=0x2 (tie, odd LSB rounds up). a=0x5, count=1 -> c=0x2 (tie, even LSB stays). count=0 with any a -> c=a, flags 0.
- Backpressure: out_ready=0, stream 6 inputs with in_valid=1 -> 5 accepted and in_ready=0 on the 6th. Raise out_ready -> results emerge in order, one per cycle, with no loss or duplication.
- Random bubbles on in_valid and out_ready over 1000 transactions -> every result matches a golden model (a>>count, guard, sticky) in order.
- Assert rst with 3 transactions in flight -> out_valid=0 and c=0 immediately, without waiting for a clock edge. After release, the first new input produces a correct result with no stale output.
